// File: rtl/move_queue_pkg.sv
// Shared Tetris definitions: command codes and move-source priority helper.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package move_queue_pkg;

    // Command codes seen by the game engine; a code of 0 means "no command".
    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_DROP   = 3'd1,
        CMD_ROTATE = 3'd2,
        CMD_LEFT   = 3'd3,
        CMD_RIGHT  = 3'd4,
        CMD_DOWN   = 3'd5
    } cmd_t;

    // Pending vector is ordered by priority: bit 0 = drop ... bit 4 = down,
    // so bit i always carries command code i+1.
    localparam int NUM_SRC = 5;

    // Code of the highest-priority (lowest-index) pending source, CMD_NONE if idle.
    function automatic logic [2:0] pick_code(input logic [NUM_SRC-1:0] pend);
        logic [2:0] code;
        code = CMD_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                code = 3'(i + 1);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/move_queue_cmd_fifo.sv
// Small command FIFO with occupancy count; head entry is read directly from storage.
// Latency: a push is visible at dout/empty one cycle after the write edge.
// Backpressure: push is ignored when full unless a pop frees a slot on the same edge.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage write; contents are never reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (!rst && !clr && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level holds on push+pop.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop) begin
                level <= level + LVL_ONE;
            end else if (do_pop && !do_push) begin
                level <= level - LVL_ONE;
            end
        end
    end

endmodule

// File: rtl/move_queue.sv
// Collects per-key move pulses into pending bits and queues them by priority.
// Latency: pulse sampled at edge E0 is pushed at E1; cmd_valid rises the cycle after E1.
// Backpressure: cmd_ready stalls pops; with a full FIFO pending bits hold and repeats set dropped.
module move_queue
    import move_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    left_pulse,
    input  logic                    right_pulse,
    input  logic                    rotate_pulse,
    input  logic                    down_pulse,
    input  logic                    drop_pulse,
    input  logic                    cmd_ready,
    output logic                    cmd_valid,
    output logic [2:0]              cmd_code,
    output logic                    dropped,
    output logic [$clog2(DEPTH):0]  level
);
    logic [NUM_SRC-1:0] pulse;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] drain;
    logic [2:0]         push_code;
    logic [2:0]         head_code;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push;

    // Priority order: bit 0 is the most urgent source.
    assign pulse = {down_pulse, right_pulse, left_pulse, rotate_pulse, drop_pulse};

    // Head outputs depend only on FIFO registers, never on the pulse inputs.
    assign cmd_valid = !fifo_empty;
    assign cmd_code  = cmd_valid ? head_code : CMD_NONE;

    // Select and drain the top pending source when the FIFO can take it.
    always_comb begin
        pop       = cmd_valid && cmd_ready;
        push_code = pick_code(pending);
        push      = (|pending) && (!fifo_full || pop);
        drain     = '0;
        if (push) begin
            drain = pending & (~pending + NUM_SRC'(1));
        end
    end

    // Pending bits: a pulse always (re)arms its bit; a drained bit clears otherwise.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pending <= '0;
        end else begin
            pending <= pulse | (pending & ~drain);
        end
    end

    // Sticky loss flag: a pulse hitting an armed bit that is not leaving this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped <= 1'b0;
        end else if (!clr && |(pulse & pending & ~drain)) begin
            dropped <= 1'b1;
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (3)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (push_code),
        .dout  (head_code),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

endmodule

// File: doc/move_queue.md
MOVE_QUEUE -- requirements
Module: move_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set FIFO entry count; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 clr  input  1  synchronous flush of queued and pending commands, e.g. on new game.
REQ-005 left_pulse, right_pulse, rotate_pulse, down_pulse, drop_pulse  input  1 each  single-cycle key-repeat pulses from the per-key input handlers.
REQ-006 cmd_ready  input  1  game engine accepts the head command this cycle.
REQ-007 cmd_valid  output  1  head command present.
REQ-008 cmd_code  output  3  head command: 1=drop, 2=rotate, 3=left, 4=right, 5=down; SHALL be 0 whenever cmd_valid=0.
REQ-009 dropped  output  1  sticky flag; a pulse was lost.
REQ-010 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-011 Each source SHALL have one pending bit, set on the edge that samples its pulse high.
REQ-012 A pulse arriving while that source's pending bit is already set and not being drained that cycle SHALL be discarded and SHALL set dropped.
REQ-013 Each cycle, the highest-priority pending bit SHALL be pushed into the FIFO and cleared, with priority drop > rotate > left > right > down; at most one push per cycle.
REQ-014 A pulse on a source whose pending bit is drained in the same cycle SHALL re-set that bit rather than be lost.
REQ-015 A push SHALL be permitted when level < DEPTH, or when level = DEPTH and a pop occurs in the same cycle; otherwise pending bits SHALL hold.
REQ-016 A pop SHALL occur on the edge where cmd_valid=1 and cmd_ready=1; cmd_ready with cmd_valid=0 SHALL have no effect.
REQ-017 Commands SHALL leave the queue in push order; cmd_valid and cmd_code SHALL be registered or derived from registered state only, with no combinational path from pulse inputs.
REQ-018 For an isolated pulse into an empty, idle queue sampled at edge E0, the command SHALL be pushed at edge E1, and cmd_valid SHALL be high in the cycle after E1 (2-cycle latency).
REQ-019 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-020 level SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push and pop.
REQ-021 When clr=1, FIFO pointers, level and all pending bits SHALL clear at that edge; pulses, pushes and pops in the same cycle SHALL be ignored; dropped SHALL be unaffected.
REQ-022 dropped SHALL clear only on rst.

Reset
REQ-023 When rst=1 at a rising edge: pending bits, pointers and level SHALL be 0, and cmd_valid, cmd_code and dropped SHALL be 0 in the following cycle.
REQ-024 rst SHALL take precedence over clr and all other inputs, including mid-transfer; FIFO storage contents need not be reset.

Structure
REQ-025 Command code constants (CMD_NONE=0 through CMD_DOWN=5) SHALL live in the shared Tetris package used by the game engine.
REQ-026 The FIFO SHALL be one sub-module, cmd_fifo, with inputs push, pop, din and clr and outputs dout, empty, full and level; the pending/priority logic SHALL stay in move_queue.

Verification
REQ-027 Single left_pulse at cycle 10, cmd_ready=1 -> cmd_valid=1 with cmd_code=3 in cycle 12 only; level returns to 0.
REQ-028 All five pulses in the same cycle, cmd_ready=1 -> codes 1,2,3,4,5 on consecutive cycles; dropped=0.
REQ-029 cmd_ready=0, DEPTH=4, six distinct pulses over cycles 0-5 -> level saturates at 4 and 2 pending bits hold; after cmd_ready=1, all 6 commands are delivered in priority/arrival order.
REQ-030 Two rotate_pulses 1 cycle apart while the FIFO is full -> second is lost and dropped=1, held until rst.
REQ-031 clr asserted with level=3 and down_pulse in the same cycle -> next cycle level=0, cmd_valid=0, down not delivered, dropped unchanged.
REQ-032 rst asserted mid-stream with level=2 -> next cycle all outputs are 0; a new drop_pulse afterward is delivered 2 cycles later.
